// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity
// encodings, transmit state encoding and parity helpers.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef logic [1:0] par_mode_t;

    // Mode 2'b11 is also treated as "no parity".
    localparam par_mode_t PAR_NONE = 2'b00;
    localparam par_mode_t PAR_EVEN = 2'b01;
    localparam par_mode_t PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

    // True when the mode inserts a parity bit after the data bits.
    function automatic logic par_enabled(input par_mode_t mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Parity bit for a byte: even gives XOR of the bits, odd its inverse.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] b,
                                       input par_mode_t mode);
        return (mode == PAR_ODD) ? ~(^b) : (^b);
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Host-side bus of the UART transmitter: write handshake, line
// configuration and status flags.
interface uart_tx_param_if #(
    parameter int DIV_W = 16,
    parameter int LVL_W = 3
);
    logic             wr;
    logic [7:0]       data;
    logic [DIV_W-1:0] div;
    logic [1:0]       par;
    logic             stop2;
    logic             clr_ovf;
    logic             rdy;
    logic             busy;
    logic [LVL_W-1:0] level;
    logic             ovf;

    // Host (bus master) side.
    modport master (
        output wr, data, div, par, stop2, clr_ovf,
        input  rdy, busy, level, ovf
    );

    // Transmitter side.
    modport slave (
        input  wr, data, div, par, stop2, clr_ovf,
        output rdy, busy, level, ovf
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the transmit shifter. Occupancy is tracked by an
// explicit counter so full and empty are exact at DEPTH; pointers wrap
// naturally because DEPTH is a power of two.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 full,
    output logic                 empty,
    output logic [LVL_W-1:0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage write.
    // NOTE: the data array has no reset; only pointers and count need one,
    // and leaving it out keeps the array mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised asynchronous serial transmitter: runtime baud divisor,
// optional even/odd parity, one or two stop bits, input FIFO and a sticky
// overflow flag. Line configuration is latched at the start of each frame.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DIV_W = 16,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_param_if.slave  bus,
    output logic            TxD
);
    tx_state_t            state;
    logic [DIV_W-1:0]     tick;
    logic [DIV_W-1:0]     div_l;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shifter;
    logic                 par_en_l;
    logic                 par_bit_l;
    logic                 stop2_l;

    logic                 full;
    logic                 empty;
    logic [LVL_W-1:0]     count;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 last_stop;

    // A write is taken only when there is room; a pop in the same cycle
    // does not free a slot for it.
    assign push      = bus.wr & ~full;
    assign bit_end   = (tick == div_l);
    assign last_stop = ~stop2_l | (bit_cnt == 3'd1);
    // Load the next byte when idle, or on the final edge of the last stop
    // bit so consecutive frames run with no idle gap.
    assign pop       = ~empty & ((state == IDLE) |
                                 ((state == STOP) & bit_end & last_stop));

    assign bus.rdy   = ~full;
    assign bus.level = count;
    assign bus.busy  = (state != IDLE) | (count != '0);

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.data),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Frame engine: state, bit timing, shifter and registered line output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tick      <= '0;
            div_l     <= '0;
            bit_cnt   <= '0;
            shifter   <= '0;
            par_en_l  <= 1'b0;
            par_bit_l <= 1'b0;
            stop2_l   <= 1'b0;
            TxD       <= 1'b1;
        end else if (pop) begin
            state     <= START;
            tick      <= '0;
            bit_cnt   <= '0;
            shifter   <= fifo_dout;
            div_l     <= bus.div;
            par_en_l  <= par_enabled(bus.par);
            par_bit_l <= parity_of(fifo_dout, bus.par);
            stop2_l   <= bus.stop2;
            TxD       <= 1'b0;
        end else if (state != IDLE) begin
            if (!bit_end) begin
                tick <= tick + DIV_W'(1);
            end else begin
                tick <= '0;
                case (state)
                    START: begin
                        state <= DATA;
                        TxD   <= shifter[0];
                    end
                    DATA: begin
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (par_en_l) begin
                                state <= PAR;
                                TxD   <= par_bit_l;
                            end else begin
                                state <= STOP;
                                TxD   <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shifter <= {1'b0, shifter[DATA_BITS-1:1]};
                            TxD     <= shifter[1];
                        end
                    end
                    PAR: begin
                        state <= STOP;
                        TxD   <= 1'b1;
                    end
                    STOP: begin
                        if (last_stop) begin
                            state <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        TxD <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        TxD   <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Sticky overflow: a dropped write wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ovf <= 1'b0;
        end else if (bus.wr && full) begin
            bus.ovf <= 1'b1;
        end else if (bus.clr_ovf) begin
            bus.ovf <= 1'b0;
        end
    end

endmodule
